// File: rtl/key_row_debounce_if.sv
// rtl/key_row_debounce_if.sv - row-line and column bundle between keypad pins and the row debouncer
//
// Signals:
//   button_in           raw asynchronous row line, active-high
//   columnas            one-hot column drive from the scan generator (clk domain)
//   DB_out              debounced row state
//   columna_presionada  column captured when the press was validated
// Modports:
//   master  drives the row line and column, observes the results (pins/bench side)
//   slave   the debouncer itself
interface key_row_debounce_if;
  logic       button_in;
  logic [3:0] columnas;
  logic       DB_out;
  logic [3:0] columna_presionada;

  modport master (
    output button_in,
    output columnas,
    input  DB_out,
    input  columna_presionada
  );

  modport slave (
    input  button_in,
    input  columnas,
    output DB_out,
    output columna_presionada
  );
endinterface

// File: rtl/key_row_debounce.sv
// rtl/key_row_debounce.sv - debounces one keypad row and captures the column driven at the validated press
//
// Ports:
//   clk      system clock (27 MHz)
//   n_reset  asynchronous active-low reset
//   row      key_row_debounce_if.slave
//              button_in (in), columnas[3:0] (in),
//              DB_out (out, registered), columna_presionada[3:0] (out, registered)
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronized disagreeing cycles before DB_out follows (2 .. 2^24-1)
//   SYNC_STAGES      depth of the input synchronizer (>= 2)
module key_row_debounce #(
  parameter int DEBOUNCE_CYCLES = 13_500,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  n_reset,
  key_row_debounce_if.slave     row
);

  localparam logic [24:0] CNT_LAST = 25'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [24:0]            cnt;
  logic                   db;
  logic [3:0]             col;

  // Oldest synchronizer stage is the only view of the row line used downstream.
  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
      col  <= 4'b0000;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], row.button_in};
      if (s == db) begin
        // Any agreeing cycle, including a one-cycle glitch back, restarts the count.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        db  <= s;
        // Capture columnas as-is on a validated press (no one-hot check);
        // clearing on release keeps col at zero whenever db is low.
        col <= s ? row.columnas : 4'b0000;
      end else begin
        cnt <= cnt + 25'd1;
      end
    end
  end

  assign row.DB_out             = db;
  assign row.columna_presionada = col;

endmodule

// File: tb/tb_key_row_debounce.sv
// tb/tb_key_row_debounce.sv - scoreboard bench for key_row_debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
module tb_key_row_debounce;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  // Edges from the first edge sampling a new input level (k=0) to the output change.
  localparam int LAT  = SYNC - 1 + DEB;

  logic clk;
  logic n_reset;

  key_row_debounce_if bus ();

  key_row_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .row    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       db;
    logic [3:0] col;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs,
  // then pop and compare once the DUT has clocked.
  task automatic step(input string tag, input logic b, input logic [3:0] c,
                      input logic e_db, input logic [3:0] e_col);
    exp_t e;
    bus.button_in = b;
    bus.columnas  = c;
    e.tag = tag;
    e.db  = e_db;
    e.col = e_col;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq(e.tag, {27'b0, bus.DB_out, bus.columna_presionada},
                    {27'b0, e.db, e.col});
  endtask

  task automatic do_reset();
    bus.button_in = 1'b0;
    n_reset = 1'b0;
    #2;
    n_reset = 1'b1;
  endtask

  int rises;
  logic prev_db;
  logic [3:0] scan_col;
  logic in_win;
  logic e_db;

  initial begin
    n_reset       = 1'b0;
    bus.button_in = 1'b1;
    bus.columnas  = 4'b0100;
    #3;

    // Reset held with the row line high: outputs stay clear.
    for (int k = 0; k < 3; k++) step("rst_hold", 1'b1, 4'b0100, 1'b0, 4'b0000);
    n_reset = 1'b1;
    for (int k = 0; k < 10; k++)
      step("rst_rel", 1'b1, 4'b0100, k >= LAT, (k >= LAT) ? 4'b0100 : 4'b0000);

    // Clean press, then the column keeps scanning while the capture holds.
    do_reset();
    for (int k = 0; k < 3; k++) step("press_idle", 1'b0, 4'b0010, 1'b0, 4'b0000);
    for (int k = 0; k < 8; k++)
      step("press", 1'b1, 4'b0010, k >= LAT, (k >= LAT) ? 4'b0010 : 4'b0000);
    for (int k = 0; k < 5; k++) step("press_hold", 1'b1, 4'b0001, 1'b1, 4'b0010);

    // Bounce pattern 1,1,1,0 never reaches DEB consecutive synchronized highs.
    do_reset();
    for (int k = 0; k < 24; k++) step("bounce", (k % 4) != 3, 4'b0100, 1'b0, 4'b0000);

    // Release: first a 3-cycle low glitch is rejected, then a held release clears.
    do_reset();
    for (int k = 0; k < 8; k++)
      step("rel_setup", 1'b1, 4'b1000, k >= LAT, (k >= LAT) ? 4'b1000 : 4'b0000);
    for (int k = 0; k < 3; k++) step("rel_glitch", 1'b0, 4'b0001, 1'b1, 4'b1000);
    for (int k = 0; k < 6; k++) step("rel_after_glitch", 1'b1, 4'b0001, 1'b1, 4'b1000);
    for (int k = 0; k < 8; k++)
      step("release", 1'b0, 4'b0010, k < LAT, (k < LAT) ? 4'b1000 : 4'b0000);

    // Scan cycle: 20-cycle dwell per column, row high only under column 0100
    // (window t=20..39), so DB_out is high for t in [20+LAT, 40+LAT).
    do_reset();
    rises   = 0;
    prev_db = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < 80; t++) begin
        case (t / 20)
          0:       scan_col = 4'b1000;
          1:       scan_col = 4'b0100;
          2:       scan_col = 4'b0010;
          default: scan_col = 4'b0001;
        endcase
        in_win = (scan_col == 4'b0100);
        e_db   = (t >= 20 + LAT) && (t < 40 + LAT);
        step("scan", in_win, scan_col, e_db, e_db ? 4'b0100 : 4'b0000);
        if (bus.DB_out && !prev_db) rises++;
        prev_db = bus.DB_out;
      end
    end
    check_eq("scan_pulses", 32'(rises), 32'd3);

    // Asynchronous reset between edges while DB_out is high.
    do_reset();
    for (int k = 0; k < 8; k++)
      step("async_setup", 1'b1, 4'b0001, k >= LAT, (k >= LAT) ? 4'b0001 : 4'b0000);
    #3;
    n_reset = 1'b0;
    #1;
    check_eq("async_rst_db",  {31'b0, bus.DB_out}, 32'd0);
    check_eq("async_rst_col", {28'b0, bus.columna_presionada}, 32'd0);
    step("async_hold", 1'b1, 4'b0001, 1'b0, 4'b0000);
    n_reset = 1'b1;
    for (int k = 0; k < 8; k++)
      step("async_rel", 1'b1, 4'b0001, k >= LAT, (k >= LAT) ? 4'b0001 : 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
